cascade_channel_scheduler: RTL and testbench
============================================

# cascade_channel_scheduler

Front-end controller for `computing_cascade`. It arbitrates round-robin among CHANELS sample sources and grants one channel per frame of FRAME_LENGTH sample pairs. It drives the cascade's `i_vld`/`x1`/`x2` and `address_registration`, waits for `ac_ph_finish`, then steers `address_output` to read that channel's phase/amplitude result and returns it tagged with the channel number.

## Interface

Parameters:
- CHANELS, 4, number of sample sources and cascade channels (≥2)
- X_WIDTH, 16, signed sample width
- FRAME_LENGTH, 5, sample pairs per frame
- TIMEOUT, 1024, maximum cycles spent in WAIT_FIN or READOUT before abort
- CH_W, $clog2(CHANELS), channel index width (derived)

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- s_vld  in  CHANELS  per-source sample valid
- s_rdy  out  CHANELS  per-source ready
- s_x1, s_x2  in  CHANELS×X_WIDTH  per-source signed samples
- c_vld  out  1  to cascade `i_vld`
- c_x1, c_x2  out  X_WIDTH  to cascade `x1`/`x2`
- c_addr_reg  out  CH_W  to cascade `address_registration`
- c_addr_out  out  CH_W  to cascade `address_output`
- c_finish  in  1  from cascade `ac_ph_finish`
- c_ovld  in  1  from cascade `o_vld`
- c_ph  in  32  signed phase from cascade
- c_ac  in  32  amplitude from cascade
- r_vld  out  1  result valid, single-cycle pulse
- r_ch  out  CH_W  result channel
- r_ph  out  32  captured phase
- r_ac  out  32  captured amplitude
- busy  out  1  high when the FSM is not in IDLE
- err_timeout  out  1  sticky; set on timeout abort
- err_unexp  out  1  sticky; set when `c_finish` or `c_ovld` arrives outside its expected state

## Operation

FSM states: IDLE, FRAME, WAIT_FIN, READOUT.
- IDLE: if any `s_vld` is high, grant the first requesting channel at or after `rr_ptr` (wrap-around). Latch `grant`. Set `c_addr_reg` = `grant`. Clear `smp_cnt`. Go to FRAME. With no request, stay in IDLE.
- FRAME: `s_rdy[grant]` = 1; all other `s_rdy` bits = 0. A transfer occurs when `s_vld[grant] & s_rdy[grant]`; each transfer increments `smp_cnt`. Source gaps of any length are allowed. When the FRAME_LENGTH-th transfer completes, go to WAIT_FIN and set `rr_ptr` = `grant`+1 mod CHANELS.
- WAIT_FIN: on `c_finish`, set `c_addr_out` = `grant` and go to READOUT.
- READOUT: on `c_ovld`, capture `c_ph`/`c_ac` into `r_ph`/`r_ac`, set `r_ch` = `grant`, pulse `r_vld` for one cycle, and go to IDLE.
- Timeout: a counter clears on entry to WAIT_FIN and on entry to READOUT. When it reaches TIMEOUT-1 in either state, set `err_timeout`, emit no result, and return to IDLE. `rr_ptr` has already advanced at that point.
- Unexpected events: `c_finish` outside WAIT_FIN, or `c_ovld` outside READOUT, sets `err_unexp` and is otherwise ignored. A `c_finish` on the same cycle as FRAME completion counts as unexpected.
- Errors clear only on reset.
- Samples pass through unmodified; there is no arithmetic on `x1`/`x2`.

## Timing

- Reset values: all outputs are 0, FSM = IDLE, `rr_ptr` = 0.
- Grant: one cycle after `s_vld` is seen in IDLE, `s_rdy[grant]` rises and `c_addr_reg` is valid.
- Sample path: registered. `c_vld`/`c_x1`/`c_x2` follow a handshake by exactly 1 cycle, and `c_vld` is high only on the cycle after a transfer. `c_x1`/`c_x2` hold their last value when `c_vld` = 0.
- Back-to-back handshakes give back-to-back `c_vld`.
- `c_addr_reg` is stable from grant until the next grant. `c_addr_out` is stable from the `c_finish` cycle +1 until the next `c_finish`.
- `r_vld` rises 1 cycle after the `c_ovld` cycle.
- Minimum frame-to-frame turnaround: FRAME_LENGTH + 3 cycles plus cascade latency.
- Reset mid-operation: every state, counter, error flag and pointer returns to its reset value on the next edge. A partial frame is dropped.

## Structure

- Package `cascade_sched_pkg`: `state_t` enum (IDLE, FRAME, WAIT_FIN, READOUT) and a `ch_w(int)` function for the channel index width.
- Sub-module `rr_arbiter` (parameter N): inputs `req[N]` and `ptr`; outputs one-hot `gnt` and `gnt_idx`. It is combinational and instantiated once.
- The top level holds the FSM, counters, the sample register stage and the result capture.

## Test plan

- Single source: ch2 sends 5 pairs (x1 = 1..5, x2 = 2..10) with 8-cycle gaps. Then `c_finish`, and `c_ovld` with ph = −100, ac = 500. Expect: `c_vld` 5×, each 1 cycle after its handshake; `c_addr_reg` = 2; `c_addr_out` = 2; `r_vld` pulse with `r_ch` = 2, `r_ph` = −100, `r_ac` = 500.
- All four sources requesting continuously, 8 frames: grant order 0,1,2,3,0,1,2,3. No `s_rdy` bit for a non-granted channel is ever high.
- Streaming: granted source holds `s_vld` high continuously for 3 frames (15 pairs). Expect 5 consecutive `c_vld` cycles per frame with no gaps.
- Timeout (TIMEOUT = 16): complete a frame and withhold `c_finish`. Expect `err_timeout` = 1 after 16 cycles, FSM back in IDLE, no `r_vld`, and the next grant goes to the next channel.
- Unexpected events: pulse `c_finish` during FRAME and `c_ovld` in IDLE. Expect `err_unexp` = 1 and frame counting unaffected.
- Reset mid-frame: assert `rstn` = 0 after 3 transfers. Expect all outputs 0, `rr_ptr` = 0, and the next frame granted to ch0 with `smp_cnt` restarting from 0.

Source files
------------

// File: rtl/cascade_sched_pkg.sv
// Shared types and helpers for the cascade channel scheduler.
package cascade_sched_pkg;

   typedef enum logic [1:0] {IDLE, FRAME, WAIT_FIN, READOUT} state_t;

   function automatic int ch_w(int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, with wrap-around.
module rr_arbiter
   import cascade_sched_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]       req,
   input  logic [ch_w(N)-1:0] ptr,
   output logic [N-1:0]       gnt,
   output logic [ch_w(N)-1:0] gnt_idx
);

   localparam int W = ch_w(N);

   int   idx;
   logic found;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = 0;
      for (int i = 0; i < N; i++) begin
         idx = (int'(ptr) + i) % N;
         if (!found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            gnt_idx  = W'(idx);
         end
      end
   end

endmodule

// File: rtl/cascade_channel_scheduler.sv
// Front-end for computing_cascade: grants one source per frame, feeds the cascade,
// then reads back that channel's phase/amplitude and returns it tagged with the channel.
module cascade_channel_scheduler
   import cascade_sched_pkg::*;
#(
   parameter int CHANELS      = 4,
   parameter int X_WIDTH      = 16,
   parameter int FRAME_LENGTH = 5,
   parameter int TIMEOUT      = 1024,
   parameter int CH_W         = ch_w(CHANELS)
) (
   input  logic                              clk,
   input  logic                              rstn,
   input  logic [CHANELS-1:0]                s_vld,
   output logic [CHANELS-1:0]                s_rdy,
   input  logic [CHANELS-1:0][X_WIDTH-1:0]   s_x1,
   input  logic [CHANELS-1:0][X_WIDTH-1:0]   s_x2,
   output logic                              c_vld,
   output logic signed [X_WIDTH-1:0]         c_x1,
   output logic signed [X_WIDTH-1:0]         c_x2,
   output logic [CH_W-1:0]                   c_addr_reg,
   output logic [CH_W-1:0]                   c_addr_out,
   input  logic                              c_finish,
   input  logic                              c_ovld,
   input  logic signed [31:0]                c_ph,
   input  logic [31:0]                       c_ac,
   output logic                              r_vld,
   output logic [CH_W-1:0]                   r_ch,
   output logic signed [31:0]                r_ph,
   output logic [31:0]                       r_ac,
   output logic                              busy,
   output logic                              err_timeout,
   output logic                              err_unexp
);

   localparam int SW = ch_w(FRAME_LENGTH + 1);
   localparam int TW = ch_w(TIMEOUT);

   state_t state_q, state_d;

   logic [CH_W-1:0]    rr_ptr_q, grant_q, addr_reg_q, addr_out_q, r_ch_q;
   logic [CHANELS-1:0] grant_oh_q;
   logic [SW-1:0]      smp_cnt_q;
   logic [TW-1:0]      tmo_cnt_q;
   logic               c_vld_q, r_vld_q, err_timeout_q, err_unexp_q;
   logic [X_WIDTH-1:0] c_x1_q, c_x2_q;
   logic [31:0]        r_ph_q, r_ac_q;

   logic [CHANELS-1:0] arb_gnt;
   logic [CH_W-1:0]    arb_idx;
   logic grant_en, xfer, frame_done, fin_take, ovld_take, tmo_hit, unexp_evt;

   rr_arbiter #(
      .N(CHANELS)
   ) u_arb (
      .req     (s_vld),
      .ptr     (rr_ptr_q),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx)
   );

   always_ff @(posedge clk) begin
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      grant_en   = 1'b0;
      xfer       = 1'b0;
      frame_done = 1'b0;
      fin_take   = 1'b0;
      ovld_take  = 1'b0;
      tmo_hit    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (|s_vld) begin
               grant_en = 1'b1;
               state_d  = FRAME;
            end
         end
         FRAME: begin
            xfer = s_vld[grant_q];
            if (xfer && smp_cnt_q == SW'(FRAME_LENGTH - 1)) begin
               frame_done = 1'b1;
               state_d    = WAIT_FIN;
            end
         end
         WAIT_FIN: begin
            if (c_finish) begin
               fin_take = 1'b1;
               state_d  = READOUT;
            end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
               tmo_hit = 1'b1;
               state_d = IDLE;
            end
         end
         READOUT: begin
            if (c_ovld) begin
               ovld_take = 1'b1;
               state_d   = IDLE;
            end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
               tmo_hit = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Cascade strobes are only legal in the state that waits for them.
   assign unexp_evt = (c_finish && state_q != WAIT_FIN) || (c_ovld && state_q != READOUT);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         rr_ptr_q      <= '0;
         grant_q       <= '0;
         grant_oh_q    <= '0;
         addr_reg_q    <= '0;
         addr_out_q    <= '0;
         smp_cnt_q     <= '0;
         tmo_cnt_q     <= '0;
         c_vld_q       <= 1'b0;
         c_x1_q        <= '0;
         c_x2_q        <= '0;
         r_vld_q       <= 1'b0;
         r_ch_q        <= '0;
         r_ph_q        <= '0;
         r_ac_q        <= '0;
         err_timeout_q <= 1'b0;
         err_unexp_q   <= 1'b0;
      end else begin
         if (grant_en) begin
            grant_q    <= arb_idx;
            grant_oh_q <= arb_gnt;
            addr_reg_q <= arb_idx;
            smp_cnt_q  <= '0;
         end
         if (xfer) begin
            smp_cnt_q <= smp_cnt_q + SW'(1);
            c_x1_q    <= s_x1[grant_q];
            c_x2_q    <= s_x2[grant_q];
         end
         c_vld_q <= xfer;
         if (frame_done) begin
            rr_ptr_q <= (grant_q == CH_W'(CHANELS - 1)) ? '0 : grant_q + CH_W'(1);
         end
         if (frame_done || fin_take) begin
            tmo_cnt_q <= '0;
         end else if (state_q == WAIT_FIN || state_q == READOUT) begin
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
         end
         if (fin_take) addr_out_q <= grant_q;
         r_vld_q <= ovld_take;
         if (ovld_take) begin
            r_ch_q <= grant_q;
            r_ph_q <= c_ph;
            r_ac_q <= c_ac;
         end
         if (tmo_hit)   err_timeout_q <= 1'b1;
         if (unexp_evt) err_unexp_q   <= 1'b1;
      end
   end

   assign s_rdy       = (state_q == FRAME) ? grant_oh_q : '0;
   assign busy        = (state_q != IDLE);
   assign c_vld       = c_vld_q;
   assign c_x1        = c_x1_q;
   assign c_x2        = c_x2_q;
   assign c_addr_reg  = addr_reg_q;
   assign c_addr_out  = addr_out_q;
   assign r_vld       = r_vld_q;
   assign r_ch        = r_ch_q;
   assign r_ph        = r_ph_q;
   assign r_ac        = r_ac_q;
   assign err_timeout = err_timeout_q;
   assign err_unexp   = err_unexp_q;

endmodule

// File: tb/tb_cascade_channel_scheduler.sv
// Bench for cascade_channel_scheduler: vector table, directed corner sequences and
// randomized traffic checked every cycle against a behavioural model.
module tb_cascade_channel_scheduler;

   localparam int CH = 4;
   localparam int XW = 16;
   localparam int FL = 5;
   localparam int TO = 16;
   localparam int CW = 2;

   logic clk = 1'b0;
   logic rstn;
   logic [CH-1:0]         s_vld, s_rdy;
   logic [CH-1:0][XW-1:0] s_x1, s_x2;
   logic                  c_vld;
   logic [XW-1:0]         c_x1, c_x2;
   logic [CW-1:0]         c_addr_reg, c_addr_out, r_ch;
   logic                  c_finish, c_ovld, r_vld, busy, err_timeout, err_unexp;
   logic [31:0]           c_ph, c_ac, r_ph, r_ac;

   always #5 clk = ~clk;

   cascade_channel_scheduler #(
      .CHANELS      (CH),
      .X_WIDTH      (XW),
      .FRAME_LENGTH (FL),
      .TIMEOUT      (TO)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .s_vld       (s_vld),
      .s_rdy       (s_rdy),
      .s_x1        (s_x1),
      .s_x2        (s_x2),
      .c_vld       (c_vld),
      .c_x1        (c_x1),
      .c_x2        (c_x2),
      .c_addr_reg  (c_addr_reg),
      .c_addr_out  (c_addr_out),
      .c_finish    (c_finish),
      .c_ovld      (c_ovld),
      .c_ph        (c_ph),
      .c_ac        (c_ac),
      .r_vld       (r_vld),
      .r_ch        (r_ch),
      .r_ph        (r_ph),
      .r_ac        (r_ac),
      .busy        (busy),
      .err_timeout (err_timeout),
      .err_unexp   (err_unexp)
   );

   int checks = 0;
   int failures = 0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endfunction

   // Behavioural model: what phase the scheduler is in and what it should show.
   typedef enum int {M_IDLE, M_FRAME, M_WAIT, M_READ} mph_t;
   mph_t          m_ph;
   int            m_ptr, m_grant, m_cnt, m_dwell;
   int            e_areg, e_aout, e_rch;
   logic          e_cvld, e_rvld, e_tmo, e_unexp;
   logic [XW-1:0] e_x1, e_x2;
   logic [31:0]   e_rph, e_rac;

   function automatic void model_step();
      e_cvld = 1'b0;
      e_rvld = 1'b0;
      if (!rstn) begin
         m_ph = M_IDLE; m_ptr = 0; m_grant = 0; m_cnt = 0; m_dwell = 0;
         e_areg = 0; e_aout = 0; e_rch = 0; e_x1 = '0; e_x2 = '0;
         e_rph = '0; e_rac = '0; e_tmo = 1'b0; e_unexp = 1'b0;
         return;
      end
      if ((c_finish && m_ph != M_WAIT) || (c_ovld && m_ph != M_READ)) e_unexp = 1'b1;
      case (m_ph)
         M_IDLE: begin
            if (s_vld != '0) begin
               // scan downwards so the closest requester at/after the pointer wins
               for (int k = CH - 1; k >= 0; k--) begin
                  if (s_vld[(m_ptr + k) % CH]) m_grant = (m_ptr + k) % CH;
               end
               e_areg = m_grant;
               m_cnt  = 0;
               m_ph   = M_FRAME;
            end
         end
         M_FRAME: begin
            if (s_vld[m_grant]) begin
               e_cvld = 1'b1;
               e_x1   = s_x1[m_grant];
               e_x2   = s_x2[m_grant];
               m_cnt++;
               if (m_cnt == FL) begin
                  m_ph    = M_WAIT;
                  m_ptr   = (m_grant + 1) % CH;
                  m_dwell = 0;
               end
            end
         end
         M_WAIT, M_READ: begin
            m_dwell++;
            if (m_ph == M_WAIT && c_finish) begin
               e_aout  = m_grant;
               m_ph    = M_READ;
               m_dwell = 0;
            end else if (m_ph == M_READ && c_ovld) begin
               e_rvld = 1'b1;
               e_rch  = m_grant;
               e_rph  = c_ph;
               e_rac  = c_ac;
               m_ph   = M_IDLE;
            end else if (m_dwell == TO) begin
               e_tmo = 1'b1;
               m_ph  = M_IDLE;
            end
         end
         default: m_ph = M_IDLE;
      endcase
   endfunction

   function automatic void compare_all();
      logic [CH-1:0] e_rdy;
      e_rdy = '0;
      if (m_ph == M_FRAME) e_rdy[m_grant] = 1'b1;
      chk("s_rdy", s_rdy, e_rdy);
      chk("c_vld", c_vld, e_cvld);
      chk("c_x1", c_x1, e_x1);
      chk("c_x2", c_x2, e_x2);
      chk("c_addr_reg", c_addr_reg, e_areg);
      chk("c_addr_out", c_addr_out, e_aout);
      chk("r_vld", r_vld, e_rvld);
      chk("r_ch", r_ch, e_rch);
      chk("r_ph", r_ph, e_rph);
      chk("r_ac", r_ac, e_rac);
      chk("busy", busy, m_ph != M_IDLE);
      chk("err_timeout", err_timeout, e_tmo);
      chk("err_unexp", err_unexp, e_unexp);
   endfunction

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
   endtask

   // Vector table: channel-2 single-source frame with 8-cycle gaps.
   typedef struct {
      logic [CH-1:0] vld;
      logic [XW-1:0] x1, x2;
      logic          fin, ovld;
      logic [31:0]   ph, ac;
      int            rep;
      logic [CH-1:0] e_rdy;
      logic          e_cvld;
      logic [XW-1:0] e_x1;
      int            e_areg, e_aout;
      logic          e_rvld;
      int            e_rch;
      logic [31:0]   e_rph;
      logic          e_busy;
   } vec_t;
   vec_t tbl[$];

   function automatic void addv(int vld, int x1, int x2, int fin, int ovld, int ph, int ac,
                                int rep, int rdy, int cv, int ex1, int areg, int aout,
                                int rv, int rch, int rph, int bsy);
      vec_t v;
      v.vld = CH'(vld); v.x1 = XW'(x1); v.x2 = XW'(x2); v.fin = (fin != 0);
      v.ovld = (ovld != 0); v.ph = 32'(ph); v.ac = 32'(ac); v.rep = rep;
      v.e_rdy = CH'(rdy); v.e_cvld = (cv != 0); v.e_x1 = XW'(ex1); v.e_areg = areg;
      v.e_aout = aout; v.e_rvld = (rv != 0); v.e_rch = rch; v.e_rph = 32'(rph);
      v.e_busy = (bsy != 0);
      tbl.push_back(v);
   endfunction

   task automatic run_frames(input logic [CH-1:0] mask, input int nfr, input int base,
                             input int stp);
      int   grants = 0;
      int   nres = 0;
      int   run = 0;
      mph_t prev;
      s_vld = mask;
      for (int cyc = 0; cyc < nfr * (FL + 3) + 20 && nres < nfr; cyc++) begin
         prev     = m_ph;
         s_x1     = {$urandom(), $urandom()};
         s_x2     = {$urandom(), $urandom()};
         c_finish = (m_ph == M_WAIT);
         c_ovld   = (m_ph == M_READ);
         c_ph     = $urandom();
         c_ac     = $urandom();
         tick();
         if (prev == M_IDLE && m_ph == M_FRAME) begin
            chk("rr_grant", c_addr_reg, (base + grants * stp) % CH);
            grants++;
         end
         if (c_vld) run++;
         else if (run != 0) begin
            chk("stream_run", run, FL);
            run = 0;
         end
         if (r_vld) nres++;
      end
      chk("frames_done", nres, nfr);
      s_vld = '0; c_finish = 1'b0; c_ovld = 1'b0;
   endtask

   initial begin
      int n;
      logic saw_rvld;
      rstn = 1'b0; s_vld = '0; s_x1 = '0; s_x2 = '0;
      c_finish = 1'b0; c_ovld = 1'b0; c_ph = '0; c_ac = '0;
      do_reset();
      do_reset();
      chk("rst_busy", busy, 0);
      chk("rst_rdy", s_rdy, 0);

      addv(4, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 2, 0, 0, 0, 0, 1);
      for (int k = 1; k <= FL; k++) begin
         addv(4, k, 2 * k, 0, 0, 0, 0, 1, (k < FL) ? 4 : 0, 1, k, 2, 0, 0, 0, 0, 1);
         if (k < FL) addv(0, 0, 0, 0, 0, 0, 0, 8, 4, 0, k, 2, 0, 0, 0, 0, 1);
      end
      addv(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, FL, 2, 2, 0, 0, 0, 1);
      addv(0, 0, 0, 0, 1, -100, 500, 1, 0, 0, FL, 2, 2, 1, 2, -100, 0);
      addv(0, 0, 0, 0, 0, 0, 0, 2, 0, 0, FL, 2, 2, 0, 2, -100, 0);
      for (int i = 0; i < tbl.size(); i++) begin
         s_vld = tbl[i].vld; s_x1 = '0; s_x2 = '0;
         s_x1[2] = tbl[i].x1; s_x2[2] = tbl[i].x2;
         c_finish = tbl[i].fin; c_ovld = tbl[i].ovld; c_ph = tbl[i].ph; c_ac = tbl[i].ac;
         for (int r = 0; r < tbl[i].rep; r++) begin
            tick();
            chk($sformatf("vec%0d_rdy", i), s_rdy, tbl[i].e_rdy);
            chk($sformatf("vec%0d_cvld", i), c_vld, tbl[i].e_cvld);
            chk($sformatf("vec%0d_cx1", i), c_x1, tbl[i].e_x1);
            chk($sformatf("vec%0d_areg", i), c_addr_reg, tbl[i].e_areg);
            chk($sformatf("vec%0d_aout", i), c_addr_out, tbl[i].e_aout);
            chk($sformatf("vec%0d_rvld", i), r_vld, tbl[i].e_rvld);
            chk($sformatf("vec%0d_rch", i), r_ch, tbl[i].e_rch);
            chk($sformatf("vec%0d_rph", i), r_ph, tbl[i].e_rph);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
         end
      end
      chk("vec_rac", r_ac, 500);
      c_ovld = 1'b0; c_ph = '0; c_ac = '0;

      // Round robin with all sources streaming, then one source streaming alone.
      do_reset();
      run_frames(4'hf, 8, 0, 1);
      run_frames(4'b0010, 3, 1, 0);

      // Timeout: frame for ch2 completes, c_finish withheld.
      s_vld = 4'hf;
      for (int i = 0; i < 20 && m_ph != M_WAIT; i++) tick();
      chk("tmo_grant", c_addr_reg, 2);
      n = 0;
      saw_rvld = 1'b0;
      while (!err_timeout && n < 40) begin
         tick();
         n++;
         if (r_vld) saw_rvld = 1'b1;
      end
      chk("tmo_cycles", n, TO);
      chk("tmo_idle", busy, 0);
      chk("tmo_no_result", saw_rvld, 0);
      tick();
      chk("tmo_next_grant", c_addr_reg, 3);
      s_vld = '0;

      // Unexpected c_finish mid-frame must not disturb the sample count.
      do_reset();
      s_vld = 4'b0001;
      for (int i = 0; i < 3; i++) tick();
      c_finish = 1'b1;
      tick();
      c_finish = 1'b0;
      chk("unexp_fin", err_unexp, 1);
      chk("unexp_fin_aout", c_addr_out, 0);
      tick();
      chk("unexp_cnt4_rdy", s_rdy, 4'b0001);
      tick();
      chk("unexp_cnt5_rdy", s_rdy, 0);
      chk("unexp_cnt5_busy", busy, 1);
      s_vld = '0; c_finish = 1'b1;
      tick();
      c_finish = 1'b0; c_ovld = 1'b1; c_ph = 32'h1234_5678; c_ac = 32'd77;
      tick();
      c_ovld = 1'b0;
      chk("unexp_rvld", r_vld, 1);
      chk("unexp_rac", r_ac, 77);
      do_reset();
      c_ovld = 1'b1;
      tick();
      c_ovld = 1'b0;
      chk("unexp_ovld_idle", err_unexp, 1);
      chk("unexp_ovld_busy", busy, 0);

      // Reset mid-frame after three transfers.
      run_frames(4'hf, 1, 0, 1);
      s_vld = 4'hf;
      tick();
      chk("midrst_grant", c_addr_reg, 1);
      for (int i = 0; i < 3; i++) tick();
      do_reset();
      chk("midrst_rdy", s_rdy, 0);
      chk("midrst_cvld", c_vld, 0);
      chk("midrst_cx1", c_x1, 0);
      chk("midrst_areg", c_addr_reg, 0);
      chk("midrst_err", err_unexp, 0);
      chk("midrst_busy", busy, 0);
      tick();
      chk("midrst_regrant", c_addr_reg, 0);
      for (int i = 0; i < FL - 1; i++) tick();
      chk("midrst_cnt4", s_rdy, 4'b0001);
      tick();
      chk("midrst_cnt5", s_rdy, 0);

      // Randomized traffic, spurious strobes and occasional resets.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         rstn     = ($urandom_range(0, 399) != 0);
         s_vld    = CH'($urandom());
         s_x1     = {$urandom(), $urandom()};
         s_x2     = {$urandom(), $urandom()};
         c_finish = (m_ph == M_WAIT) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 49) == 0);
         c_ovld   = (m_ph == M_READ) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 49) == 0);
         c_ph     = $urandom();
         c_ac     = $urandom();
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
